// File: rtl/phy_rst_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : phy_rst_seq                                              |
// | Description : RGMII PHY bring-up sequencer. Waits for stable MMCM      |
// |               lock, pulses the PHY hardware reset, waits for the PHY   |
// |               to settle, then releases the fabric Ethernet datapath.   |
// |               Lock loss restarts the sequence. PHY interrupts are      |
// |               latched while READY.                                     |
// | Options     : define PHY_RST_SEQ_TIMEOUT_EN to add the WAIT_LOCK       |
// |               timeout, the FAULT state and the faultOut port.          |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module phy_rst_seq #(
  parameter int LOCK_STABLE_CYCLES  = 1000,
  parameter int PHY_RST_CYCLES      = 1_000_000,
  parameter int PHY_WAIT_CYCLES     = 5_000_000,
  parameter int LOCK_TIMEOUT_CYCLES = 10_000_000
) (
  input  logic       clkIn,
  input  logic       rstIn,
  input  logic       mmcm0LockedIn,
  input  logic       mmcm1LockedIn,
  input  logic       intBIn,
  input  logic       intAckIn,
  output logic       phyRstBOut,
  output logic       datapathRstOut,
  output logic       readyOut,
  output logic       intPendingOut,
  output logic [7:0] lockLossCntOut,
  output logic [2:0] stateOut
`ifdef PHY_RST_SEQ_TIMEOUT_EN
  ,
  output logic       faultOut
`endif
);

  // One shared cycle counter, wide enough for the longest interval.
  localparam int c_MAX_A = (LOCK_STABLE_CYCLES > PHY_RST_CYCLES) ? LOCK_STABLE_CYCLES : PHY_RST_CYCLES;
  localparam int c_MAX_B = (PHY_WAIT_CYCLES > LOCK_TIMEOUT_CYCLES) ? PHY_WAIT_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_CW    = (c_MAX > 1) ? $clog2(c_MAX) : 1;

  // Terminal counts: the counter starts at 0 on state entry.
  localparam logic [c_CW-1:0] c_LS_LAST = c_CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_PR_LAST = c_CW'(PHY_RST_CYCLES - 1);
  localparam logic [c_CW-1:0] c_PW_LAST = c_CW'(PHY_WAIT_CYCLES - 1);
`ifdef PHY_RST_SEQ_TIMEOUT_EN
  localparam logic [c_CW-1:0] c_LT_LAST = c_CW'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_LOCK_STABLE = 3'd2,
    S_PHY_RST     = 3'd3,
    S_PHY_WAIT    = 3'd4,
    S_READY       = 3'd5,
    S_FAULT       = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic            w_cnt_run;

  logic r_lock0_meta, r_lock0_sync;
  logic r_lock1_meta, r_lock1_sync;
  logic r_intB_meta, r_intB_sync, r_intB_d;
  logic w_locks;
  logic w_int_fall;

  logic       r_phy_rst_b;
  logic       r_dp_rst;
  logic       r_ready;
  logic       r_int_pend;
  logic [7:0] r_loss_cnt;
`ifdef PHY_RST_SEQ_TIMEOUT_EN
  logic       r_fault;
`endif

  // Two-flop synchronisers for the asynchronous inputs, plus an edge-detect stage for intB.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_lock0_meta <= 1'b0;
      r_lock0_sync <= 1'b0;
      r_lock1_meta <= 1'b0;
      r_lock1_sync <= 1'b0;
      r_intB_meta  <= 1'b1;
      r_intB_sync  <= 1'b1;
      r_intB_d     <= 1'b1;
    end else begin
      r_lock0_meta <= mmcm0LockedIn;
      r_lock0_sync <= r_lock0_meta;
      r_lock1_meta <= mmcm1LockedIn;
      r_lock1_sync <= r_lock1_meta;
      r_intB_meta  <= intBIn;
      r_intB_sync  <= r_intB_meta;
      r_intB_d     <= r_intB_sync;
    end
  end

  assign w_locks    = r_lock0_sync & r_lock1_sync;
  assign w_int_fall = r_intB_d & ~r_intB_sync;

  // Next-state selection; lock loss always wins over interval completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:        w_state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (w_locks) w_state_nxt = S_LOCK_STABLE;
`ifdef PHY_RST_SEQ_TIMEOUT_EN
        else if (r_cnt == c_LT_LAST) w_state_nxt = S_FAULT;
`endif
      end
      S_LOCK_STABLE: begin
        if (!w_locks) w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == c_LS_LAST) w_state_nxt = S_PHY_RST;
      end
      S_PHY_RST: begin
        if (!w_locks) w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == c_PR_LAST) w_state_nxt = S_PHY_WAIT;
      end
      S_PHY_WAIT: begin
        if (!w_locks) w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == c_PW_LAST) w_state_nxt = S_READY;
      end
      S_READY: begin
        if (!w_locks) w_state_nxt = S_WAIT_LOCK;
      end
      S_FAULT:       w_state_nxt = S_FAULT;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  // Only the timed states advance the counter, so it never wraps.
  always_comb begin
    w_cnt_run = (r_state == S_LOCK_STABLE) || (r_state == S_PHY_RST) || (r_state == S_PHY_WAIT);
`ifdef PHY_RST_SEQ_TIMEOUT_EN
    if (r_state == S_WAIT_LOCK) w_cnt_run = 1'b1;
`endif
  end

  // State, counter and registered outputs, all decoded from the state being entered.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_phy_rst_b <= 1'b0;
      r_dp_rst    <= 1'b1;
      r_ready     <= 1'b0;
      r_int_pend  <= 1'b0;
      r_loss_cnt  <= 8'd0;
`ifdef PHY_RST_SEQ_TIMEOUT_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_cnt_run) r_cnt <= r_cnt + 1'b1;

      r_phy_rst_b <= (w_state_nxt == S_PHY_WAIT) || (w_state_nxt == S_READY);
      r_ready     <= (w_state_nxt == S_READY);
      r_dp_rst    <= (w_state_nxt != S_READY);
`ifdef PHY_RST_SEQ_TIMEOUT_EN
      r_fault     <= (w_state_nxt == S_FAULT);
`endif

      if ((r_state == S_READY) && !w_locks && (r_loss_cnt != 8'hFF))
        r_loss_cnt <= r_loss_cnt + 8'd1;

      // A new edge takes precedence over a coincident ack.
      if ((r_state == S_READY) && (w_state_nxt == S_READY)) begin
        if (w_int_fall) r_int_pend <= 1'b1;
        else if (intAckIn) r_int_pend <= 1'b0;
      end else begin
        r_int_pend <= 1'b0;
      end
    end
  end

  assign phyRstBOut     = r_phy_rst_b;
  assign datapathRstOut = r_dp_rst;
  assign readyOut       = r_ready;
  assign intPendingOut  = r_int_pend;
  assign lockLossCntOut = r_loss_cnt;
  assign stateOut       = r_state;
`ifdef PHY_RST_SEQ_TIMEOUT_EN
  assign faultOut       = r_fault;
`endif

endmodule
`default_nettype wire
